piso_serializer: RTL and testbench

//   Parallel-in serial-out stage directly downstream of the PIPO register.

---
 rtl/piso_serializer.sv | 104 ++++++++++
 tb/tb_piso_serializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word capture and gapless one-bit-per-clock shift-out with frame flags.
// Define PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
    state_t state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0] cnt, cnt_n;
    logic sout_n, start_n, done_n, accept, last;
`ifdef PARITY_EN
    logic par, par_n;
`endif
    // cnt indexes the bit currently on sout, so last marks the final data bit
    assign last = state == SHIFT && cnt == CW'(WIDTH - 1);
`ifdef PARITY_EN
    assign din_ready = reset && (state == IDLE || state == PAR);
`else
    assign din_ready = reset && (state == IDLE || last);
`endif
    assign accept = din_valid && din_ready;
    assign busy = state != IDLE;
    assign sout_valid = busy;

    always_comb begin
        state_n = state;
        sreg_n = sreg;
        cnt_n = cnt;
        sout_n = 1'b0;
        start_n = 1'b0;
        done_n = 1'b0;
`ifdef PARITY_EN
        par_n = par;
`endif
        if (accept) begin
            state_n = SHIFT;
            cnt_n = '0;
            sout_n = MSB_FIRST != 0 ? din[WIDTH-1] : din[0];
            sreg_n = MSB_FIRST != 0 ? din << 1 : din >> 1;
            start_n = 1'b1;
`ifdef PARITY_EN
            par_n = ^din;
`endif
        end else if (state == SHIFT && !last) begin
            cnt_n = cnt + CW'(1);
            sout_n = MSB_FIRST != 0 ? sreg[WIDTH-1] : sreg[0];
            sreg_n = MSB_FIRST != 0 ? sreg << 1 : sreg >> 1;
`ifdef PARITY_EN
`else
            done_n = cnt == CW'(WIDTH - 2);
`endif
        end else begin
            state_n = IDLE;
`ifdef PARITY_EN
            if (last) begin
                state_n = PAR;
                sout_n = par;
                done_n = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sreg <= '0;
            cnt <= '0;
            sout <= 1'b0;
            frame_start <= 1'b0;
            frame_done <= 1'b0;
`ifdef PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            state <= state_n;
            sreg <= sreg_n;
            cnt <= cnt_n;
            sout <= sout_n;
            frame_start <= start_n;
            frame_done <= done_n;
`ifdef PARITY_EN
            par <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of the serializer, MSB-first and LSB-first instances.
// Observed vectors are {sout, sout_valid, frame_start, frame_done, busy, din_ready}.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] din = 4'b0;
    logic din_valid = 1'b0;
    logic din_ready, sout, sout_valid, frame_start, frame_done, busy;
    logic l_ready, l_sout, l_valid, l_start, l_done, l_busy;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start),
        .frame_done(frame_done), .busy(busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(l_ready),
        .sout(l_sout), .sout_valid(l_valid), .frame_start(l_start),
        .frame_done(l_done), .busy(l_busy)
    );

    task automatic send(input logic [3:0] w);
        @(posedge clk);
        #1 din = w;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] obs;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            obs = {sout, sout_valid, frame_start, frame_done, busy, 1'b0};
            checks++;
            if (obs !== 6'b000000) begin
                errors++;
                $display("FAIL reset_hold got %b exp 000000", obs);
            end
        end
        reset = 1'b1;
        #1 obs = {sout, sout_valid, frame_start, frame_done, busy, din_ready};
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL reset_release got %b exp 000001", obs);
        end
    endtask

    task automatic test_single;
        logic [5:0] exp_v [5];
        logic [5:0] obs;
        exp_v = '{6'b111010, 6'b010010, 6'b010010, 6'b110111, 6'b000001};
        send(4'b1001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            obs = {sout, sout_valid, frame_start, frame_done, busy, din_ready};
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL single c%0d got %b exp %b", i + 1, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] pat;
        logic [5:0] obs, e;
        pat = 8'b10101111;
        @(posedge clk);
        #1 din = 4'b1010;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e = {pat[7-i], 1'b1, i % 4 == 0, i % 4 == 3, 1'b1, i % 4 == 3};
            obs = {sout, sout_valid, frame_start, frame_done, busy, din_ready};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL b2b c%0d got %b exp %b", i + 1, obs, e);
            end
            if (i == 3) begin
                @(posedge clk);
                #1 din_valid = 1'b0;
            end
        end
        @(negedge clk);
        obs = {sout, sout_valid, frame_start, frame_done, busy, din_ready};
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL b2b_idle got %b exp 000001", obs);
        end
    endtask

    task automatic test_abort;
        logic [3:0] pat;
        logic [5:0] obs;
        send(4'b1111);
        @(negedge clk);
        obs = {sout, sout_valid, frame_start, frame_done, busy, din_ready};
        checks++;
        if (obs !== 6'b111010) begin
            errors++;
            $display("FAIL abort_c1 got %b exp 111010", obs);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1 obs = {sout, sout_valid, frame_start, frame_done, busy, din_ready};
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL abort_now got %b exp 000000", obs);
        end
        repeat (2) begin
            @(negedge clk);
            obs = {sout, sout_valid, frame_start, frame_done, busy, 1'b0};
            checks++;
            if (obs !== 6'b000000) begin
                errors++;
                $display("FAIL abort_hold got %b exp 000000", obs);
            end
        end
        reset = 1'b1;
        #1 checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready got %b exp 1", din_ready);
        end
        pat = 4'b0110;
        send(pat);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({sout, sout_valid, frame_start} !== {pat[3-i], 1'b1, i == 0}) begin
                errors++;
                $display("FAIL abort_reload c%0d got %b exp %b", i + 1,
                         {sout, sout_valid, frame_start}, {pat[3-i], 1'b1, i == 0});
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lsb_first;
        logic [3:0] l_exp, m_exp;
        logic [4:0] obs, e;
        l_exp = 4'b0011;
        m_exp = 4'b1100;
        send(4'b1100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = {l_exp[3-i], 1'b1, i == 0, i == 3, 1'b1};
            obs = {l_sout, l_valid, l_start, l_done, l_busy};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL lsb c%0d got %b exp %b", i + 1, obs, e);
            end
            checks++;
            if (sout !== m_exp[3-i]) begin
                errors++;
                $display("FAIL lsb_vs_msb c%0d got %b exp %b", i + 1, sout, m_exp[3-i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_parity;
        logic [5:0] exp_v [6];
        logic [5:0] obs;
        exp_v = '{6'b111010, 6'b010010, 6'b110010, 6'b110010, 6'b110111, 6'b000001};
        send(4'b1011);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            obs = {sout, sout_valid, frame_start, frame_done, busy, din_ready};
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL parity c%0d got %b exp %b", i + 1, obs, exp_v[i]);
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef PARITY_EN
        test_parity();
        test_abort();
`else
        test_single();
        test_back_to_back();
        test_abort();
        test_lsb_first();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
